// File: rtl/trace_pkg.sv
// Shared record layout and kind encoding for the commit trace path.
// Latency: n/a (types and a pure classification function only).
// Backpressure: n/a.
package trace_pkg;

  // Kind of retired instruction carried in each trace record.
  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_REG   = 2'd1,
    KIND_STORE = 2'd2,
    KIND_HALT  = 2'd3
  } kind_e;

  // One trace record: kind 2 + pc 32 + inst 32 + addr 32 + data 32.
  typedef struct packed {
    kind_e       kind;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  // HALT wins over STORE, STORE over REG; a write to x0 is not a register update.
  function automatic kind_e classify(input logic halt, input logic dmem_we,
                                     input logic reg_we, input logic [4:0] reg_wa);
    if (halt)                        return KIND_HALT;
    else if (dmem_we)                return KIND_STORE;
    else if (reg_we && reg_wa != '0) return KIND_REG;
    else                             return KIND_NONE;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular-buffer FIFO holding trace records between capture and drain.
// Latency: a record pushed at edge N is visible at the head after edge N.
// Backpressure: out_vld/out_rdy drain; a push when full is accepted only alongside a pop.
module trace_fifo #(
  parameter int WIDTH = 130,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  output logic                       push_acc,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [WIDTH-1:0]           out_dat,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     count_nxt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             pop;

  // Handshake decode and next pointer/occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    full     = (count_q == CW'(DEPTH));
    out_vld  = (count_q != '0);
    pop      = out_vld && out_rdy;
    push_acc = push_vld && (!full || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_acc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards any queued records.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage; contents are meaningless while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr_q] <= push_dat;
  end

  assign out_dat   = mem[rd_ptr_q];
  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

// File: rtl/commit_tracer.sv
// Captures retired-instruction records, classifies them and queues them for drain.
// Latency: a capture at edge N is presented on trace_* after edge N when the queue was empty.
// Backpressure: trace_valid/trace_ready drain; cpu_hold asks the core to stall near full, overflow drops are sticky.
module commit_tracer
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        global_en,
  input  logic        commit,
  input  logic [31:0] commit_pc,
  input  logic [31:0] commit_inst,
  input  logic        commit_halt,
  input  logic        commit_reg_we,
  input  logic [4:0]  commit_reg_wa,
  input  logic [31:0] commit_reg_wd,
  input  logic        commit_dmem_we,
  input  logic [31:0] commit_dmem_wa,
  input  logic [31:0] commit_dmem_wd,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_inst,
  output logic [1:0]  trace_kind,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        cpu_hold,
  output logic [31:0] inst_count,
  output logic [31:0] cycle_count,
  output logic        halted,
  output logic        done,
  output logic        overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic        capture;
  trace_rec_t  rec;
  trace_rec_t  head;
  logic [REC_W-1:0] head_dat;
  logic        push_acc;
  logic        fifo_full;
  logic [CW-1:0] fifo_count, fifo_count_nxt;

  logic        halted_q, halted_d;
  logic        overflow_q, overflow_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic [31:0] inst_count_q, inst_count_d;
  logic [31:0] cycle_count_q, cycle_count_d;

  // Build the record for this cycle's commit and compute next counter/status state.
  always_comb begin
    capture   = commit && global_en && !halted_q;
    rec       = '0;
    rec.kind  = classify(commit_halt, commit_dmem_we, commit_reg_we, commit_reg_wa);
    rec.pc    = commit_pc;
    rec.inst  = commit_inst;
    case (rec.kind)
      KIND_REG: begin
        rec.addr = {27'b0, commit_reg_wa};
        rec.data = commit_reg_wd;
      end
      KIND_STORE: begin
        rec.addr = commit_dmem_wa;
        rec.data = commit_dmem_wd;
      end
      default: begin
        rec.addr = '0;
        rec.data = '0;
      end
    endcase

    halted_d      = halted_q || (capture && rec.kind == KIND_HALT);
    overflow_d    = overflow_q || (capture && !push_acc);
    inst_count_d  = capture ? inst_count_q + 32'd1 : inst_count_q;
    cycle_count_d = (global_en && !halted_q) ? cycle_count_q + 32'd1 : cycle_count_q;
    cpu_hold_d    = (fifo_count_nxt >= CW'(DEPTH - 2));
  end

  // Status and counter registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q      <= 1'b0;
      overflow_q    <= 1'b0;
      cpu_hold_q    <= 1'b0;
      inst_count_q  <= '0;
      cycle_count_q <= '0;
    end else begin
      halted_q      <= halted_d;
      overflow_q    <= overflow_d;
      cpu_hold_q    <= cpu_hold_d;
      inst_count_q  <= inst_count_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_vld  (capture),
    .push_dat  (rec),
    .push_acc  (push_acc),
    .out_vld   (trace_valid),
    .out_rdy   (trace_ready),
    .out_dat   (head_dat),
    .full      (fifo_full),
    .count     (fifo_count),
    .count_nxt (fifo_count_nxt)
  );

  assign head        = trace_rec_t'(head_dat);
  assign trace_kind  = head.kind;
  assign trace_pc    = head.pc;
  assign trace_inst  = head.inst;
  assign trace_addr  = head.addr;
  assign trace_data  = head.data;

  assign cpu_hold    = cpu_hold_q;
  assign inst_count  = inst_count_q;
  assign cycle_count = cycle_count_q;
  assign halted      = halted_q;
  assign overflow    = overflow_q || (fifo_full && 1'b0);
  assign done        = halted_q && (fifo_count == '0);

endmodule

// File: tb/tb_commit_tracer.sv
// Directed self-checking bench for commit_tracer.
// Latency: inputs driven 1ns after a rising edge, outputs sampled 1ns after the next.
// Backpressure: trace_ready driven directly by each scenario.
module tb_commit_tracer;

  logic        clk = 1'b0;
  logic        rst;
  logic        global_en;
  logic        commit;
  logic [31:0] commit_pc, commit_inst;
  logic        commit_halt;
  logic        commit_reg_we;
  logic [4:0]  commit_reg_wa;
  logic [31:0] commit_reg_wd;
  logic        commit_dmem_we;
  logic [31:0] commit_dmem_wa, commit_dmem_wd;
  logic        trace_valid, trace_ready;
  logic [31:0] trace_pc, trace_inst, trace_addr, trace_data;
  logic [1:0]  trace_kind;
  logic        cpu_hold;
  logic [31:0] inst_count, cycle_count;
  logic        halted, done, overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  commit_tracer #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .global_en(global_en), .commit(commit),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_halt(commit_halt),
    .commit_reg_we(commit_reg_we), .commit_reg_wa(commit_reg_wa), .commit_reg_wd(commit_reg_wd),
    .commit_dmem_we(commit_dmem_we), .commit_dmem_wa(commit_dmem_wa), .commit_dmem_wd(commit_dmem_wd),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_inst(trace_inst), .trace_kind(trace_kind),
    .trace_addr(trace_addr), .trace_data(trace_data),
    .cpu_hold(cpu_hold), .inst_count(inst_count), .cycle_count(cycle_count),
    .halted(halted), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_commit();
    commit = 0; commit_pc = 0; commit_inst = 0; commit_halt = 0;
    commit_reg_we = 0; commit_reg_wa = 0; commit_reg_wd = 0;
    commit_dmem_we = 0; commit_dmem_wa = 0; commit_dmem_wd = 0;
  endtask

  task automatic do_reset();
    rst = 1; global_en = 0; trace_ready = 0;
    clear_commit();
    tick();
    rst = 0; global_en = 1;
  endtask

  task automatic test_reset();
    rst = 1; global_en = 0; trace_ready = 0;
    clear_commit();
    tick(); tick();
    rst = 0;
    total_cnt++; if (trace_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", trace_valid); else pass_cnt++;
    total_cnt++; if (inst_count !== 32'd0) $display("FAIL reset_inst got=%0d exp=0", inst_count); else pass_cnt++;
    total_cnt++; if (cycle_count !== 32'd0) $display("FAIL reset_cycle got=%0d exp=0", cycle_count); else pass_cnt++;
    total_cnt++; if ({halted, overflow, cpu_hold, done} !== 4'b0000)
      $display("FAIL reset_flags got=%b exp=0000", {halted, overflow, cpu_hold, done}); else pass_cnt++;
    global_en = 1;
    tick(); tick(); tick();
    total_cnt++; if (cycle_count !== 32'd3) $display("FAIL cycle_run got=%0d exp=3", cycle_count); else pass_cnt++;
  endtask

  task automatic test_reg();
    do_reset();
    trace_ready = 1;
    commit = 1; commit_pc = 32'h0000_3000; commit_inst = 32'h0050_0293;
    commit_reg_we = 1; commit_reg_wa = 5; commit_reg_wd = 32'h1234;
    tick();
    clear_commit();
    total_cnt++; if (trace_valid !== 1'b1) $display("FAIL reg_valid got=%b exp=1", trace_valid); else pass_cnt++;
    total_cnt++; if (trace_kind !== 2'd1) $display("FAIL reg_kind got=%0d exp=1", trace_kind); else pass_cnt++;
    total_cnt++; if (trace_addr !== 32'd5) $display("FAIL reg_addr got=%h exp=5", trace_addr); else pass_cnt++;
    total_cnt++; if (trace_data !== 32'h1234) $display("FAIL reg_data got=%h exp=1234", trace_data); else pass_cnt++;
    total_cnt++; if (trace_pc !== 32'h3000 || trace_inst !== 32'h0050_0293)
      $display("FAIL reg_pc_inst got=%h/%h exp=3000/00500293", trace_pc, trace_inst); else pass_cnt++;
    total_cnt++; if (inst_count !== 32'd1) $display("FAIL reg_inst_count got=%0d exp=1", inst_count); else pass_cnt++;
    tick();
    total_cnt++; if (trace_valid !== 1'b0) $display("FAIL reg_drained got=%b exp=0", trace_valid); else pass_cnt++;
  endtask

  task automatic test_store_none();
    do_reset();
    trace_ready = 1;
    commit = 1; commit_pc = 32'h40;
    commit_dmem_we = 1; commit_dmem_wa = 32'h10; commit_dmem_wd = 32'hAB;
    commit_reg_we = 1; commit_reg_wa = 7; commit_reg_wd = 32'h55;
    tick();
    total_cnt++; if (trace_kind !== 2'd2) $display("FAIL store_kind got=%0d exp=2", trace_kind); else pass_cnt++;
    total_cnt++; if (trace_addr !== 32'h10 || trace_data !== 32'hAB)
      $display("FAIL store_addr_data got=%h/%h exp=10/ab", trace_addr, trace_data); else pass_cnt++;
    clear_commit();
    commit = 1; commit_pc = 32'h44; commit_reg_we = 1; commit_reg_wa = 0; commit_reg_wd = 32'h77;
    tick();
    clear_commit();
    total_cnt++; if (trace_valid !== 1'b1 || trace_pc !== 32'h44)
      $display("FAIL x0_head got=%b/%h exp=1/44", trace_valid, trace_pc); else pass_cnt++;
    total_cnt++; if (trace_kind !== 2'd0) $display("FAIL x0_kind got=%0d exp=0", trace_kind); else pass_cnt++;
    total_cnt++; if (trace_addr !== 32'd0 || trace_data !== 32'd0)
      $display("FAIL x0_addr_data got=%h/%h exp=0/0", trace_addr, trace_data); else pass_cnt++;
    tick();
    total_cnt++; if (trace_valid !== 1'b0 || inst_count !== 32'd2)
      $display("FAIL store_end got=%b/%0d exp=0/2", trace_valid, inst_count); else pass_cnt++;
  endtask

  task automatic test_held_commit();
    do_reset();
    trace_ready = 0;
    commit = 1; commit_pc = 32'h4000;
    tick();
    global_en = 0;
    repeat (5) tick();
    total_cnt++; if (inst_count !== 32'd1) $display("FAIL held_inst got=%0d exp=1", inst_count); else pass_cnt++;
    total_cnt++; if (cycle_count !== 32'd1) $display("FAIL held_cycle got=%0d exp=1", cycle_count); else pass_cnt++;
    total_cnt++; if (trace_valid !== 1'b1 || trace_pc !== 32'h4000)
      $display("FAIL held_head got=%b/%h exp=1/4000", trace_valid, trace_pc); else pass_cnt++;
    clear_commit();
    global_en = 1;
    trace_ready = 1;
    tick();
    total_cnt++; if (trace_valid !== 1'b0) $display("FAIL held_one_record got=%b exp=0", trace_valid); else pass_cnt++;
  endtask

  task automatic test_overflow_drain();
    do_reset();
    trace_ready = 0;
    for (int i = 0; i < 10; i++) begin
      commit = 1; commit_pc = 32'h100 + 32'(4 * i);
      commit_reg_we = 1; commit_reg_wa = 1; commit_reg_wd = 32'(i);
      tick();
      total_cnt++; if (cpu_hold !== ((i + 1) >= 6))
        $display("FAIL hold_%0d got=%b exp=%b", i, cpu_hold, ((i + 1) >= 6)); else pass_cnt++;
      total_cnt++; if (overflow !== (i >= 8))
        $display("FAIL ovf_%0d got=%b exp=%b", i, overflow, (i >= 8)); else pass_cnt++;
    end
    clear_commit();
    total_cnt++; if (inst_count !== 32'd10) $display("FAIL ovf_inst got=%0d exp=10", inst_count); else pass_cnt++;
    trace_ready = 1;
    for (int k = 0; k < 8; k++) begin
      total_cnt++; if (trace_valid !== 1'b1 || trace_pc !== 32'h100 + 32'(4 * k))
        $display("FAIL drain_%0d got=%b/%h exp=1/%h", k, trace_valid, trace_pc, 32'h100 + 32'(4 * k)); else pass_cnt++;
      tick();
    end
    total_cnt++; if (trace_valid !== 1'b0) $display("FAIL drain_empty got=%b exp=0", trace_valid); else pass_cnt++;
    total_cnt++; if (cpu_hold !== 1'b0 || overflow !== 1'b1)
      $display("FAIL drain_flags got=%b/%b exp=0/1", cpu_hold, overflow); else pass_cnt++;
  endtask

  task automatic test_halt();
    do_reset();
    trace_ready = 0;
    commit = 1; commit_pc = 32'h200; commit_reg_we = 1; commit_reg_wa = 2; commit_reg_wd = 32'h11;
    tick();
    clear_commit();
    commit = 1; commit_pc = 32'h204; commit_halt = 1;
    commit_reg_we = 1; commit_reg_wa = 3; commit_reg_wd = 32'h99;
    tick();
    clear_commit();
    total_cnt++; if (halted !== 1'b1) $display("FAIL halt_set got=%b exp=1", halted); else pass_cnt++;
    commit = 1; commit_pc = 32'h208; commit_reg_we = 1; commit_reg_wa = 4;
    repeat (3) tick();
    clear_commit();
    total_cnt++; if (inst_count !== 32'd2) $display("FAIL halt_inst got=%0d exp=2", inst_count); else pass_cnt++;
    total_cnt++; if (cycle_count !== 32'd2) $display("FAIL halt_cycle got=%0d exp=2", cycle_count); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL halt_done_early got=%b exp=0", done); else pass_cnt++;
    trace_ready = 1;
    total_cnt++; if (trace_pc !== 32'h200 || trace_kind !== 2'd1)
      $display("FAIL halt_head0 got=%h/%0d exp=200/1", trace_pc, trace_kind); else pass_cnt++;
    tick();
    total_cnt++; if (trace_valid !== 1'b1 || trace_pc !== 32'h204 || trace_kind !== 2'd3)
      $display("FAIL halt_head1 got=%b/%h/%0d exp=1/204/3", trace_valid, trace_pc, trace_kind); else pass_cnt++;
    total_cnt++; if (trace_addr !== 32'd0 || trace_data !== 32'd0)
      $display("FAIL halt_addr_data got=%h/%h exp=0/0", trace_addr, trace_data); else pass_cnt++;
    tick();
    total_cnt++; if (trace_valid !== 1'b0 || done !== 1'b1)
      $display("FAIL halt_done got=%b/%b exp=0/1", trace_valid, done); else pass_cnt++;
  endtask

  task automatic test_rst_flush();
    do_reset();
    trace_ready = 0;
    for (int i = 0; i < 4; i++) begin
      commit = 1; commit_pc = 32'h300 + 32'(4 * i);
      commit_halt = (i == 3);
      tick();
    end
    clear_commit();
    total_cnt++; if (halted !== 1'b1 || trace_valid !== 1'b1)
      $display("FAIL flush_pre got=%b/%b exp=1/1", halted, trace_valid); else pass_cnt++;
    rst = 1; trace_ready = 1; commit = 1; commit_pc = 32'h400;
    tick();
    rst = 0; clear_commit();
    total_cnt++; if (trace_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", trace_valid); else pass_cnt++;
    total_cnt++; if (inst_count !== 32'd0 || cycle_count !== 32'd0)
      $display("FAIL flush_counts got=%0d/%0d exp=0/0", inst_count, cycle_count); else pass_cnt++;
    total_cnt++; if ({halted, overflow, cpu_hold} !== 3'b000)
      $display("FAIL flush_flags got=%b exp=000", {halted, overflow, cpu_hold}); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_reg();
    test_store_none();
    test_held_commit();
    test_overflow_drain();
    test_halt();
    test_rst_flush();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
